// File: rtl/rn_pkg.sv
// Shared state encoding and flit-width helpers for request_node_mc.
// Default widths are 32-bit; the top module overrides them via parameters.
package rn_pkg;
  localparam int RN_ADDR_WIDTH = 32;
  localparam int RN_DATA_WIDTH = 32;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} rn_state_e;

  function automatic int req_flit_width(input int aw, input int dw);
    return aw + 5 + dw + dw / 8;
  endfunction

  function automatic int rsp_flit_width(input int dw);
    return dw + 1;
  endfunction

  localparam int REQ_FLIT_WIDTH = req_flit_width(RN_ADDR_WIDTH, RN_DATA_WIDTH);
  localparam int RSP_FLIT_WIDTH = rsp_flit_width(RN_DATA_WIDTH);
endpackage

// File: rtl/rn_port_demux.sv
// Channel steering for request_node_mc: one-hot request/response strobes,
// per-slot request flits, and selection of the destination's ready/response.
module rn_port_demux #(
  parameter int NUM_CN   = 4,
  parameter int ID_WIDTH = 4,
  parameter int REQ_W    = 73,
  parameter int RSP_W    = 33
) (
  input  logic [ID_WIDTH-1:0]     dest,
  input  logic                    req_en,
  input  logic                    rsp_en,
  input  logic [REQ_W-1:0]        flit,
  input  logic [NUM_CN-1:0]       cn_ready,
  input  logic [NUM_CN-1:0]       cn_rsp_valid,
  input  logic [NUM_CN*RSP_W-1:0] icn_rxrsp,
  output logic [NUM_CN-1:0]       rn_valid,
  output logic [NUM_CN-1:0]       rn_rsp_ready,
  output logic [NUM_CN*REQ_W-1:0] icn_txreq,
  output logic                    ready_sel,
  output logic                    rsp_valid_sel,
  output logic [RSP_W-1:0]        rsp_sel
);
  logic [NUM_CN-1:0] hit;

  // An out-of-range dest hits no channel, so nothing is driven for it.
  for (genvar i = 0; i < NUM_CN; i++) begin : g_ch
    assign hit[i]          = (dest == ID_WIDTH'(i));
    assign rn_valid[i]     = req_en & hit[i];
    assign rn_rsp_ready[i] = rsp_en & hit[i];
    assign icn_txreq[i*REQ_W +: REQ_W] = rn_valid[i] ? flit : '0;
  end

  assign ready_sel     = |(cn_ready & hit);
  assign rsp_valid_sel = |(cn_rsp_valid & hit);

  always_comb begin
    rsp_sel = '0;
    for (int i = 0; i < NUM_CN; i++)
      if (hit[i]) rsp_sel = icn_rxrsp[i*RSP_W +: RSP_W];
  end
endmodule

// File: rtl/request_node_mc.sv
// Multi-completer APB request node: one outstanding APB access routed to one of
// NUM_CN ICN channels by the address ID field. Optional handshake timeout: RN_TIMEOUT_EN.
module request_node_mc import rn_pkg::*; #(
  parameter int ADDR_WIDTH     = RN_ADDR_WIDTH,
  parameter int DATA_WIDTH     = RN_DATA_WIDTH,
  parameter int NUM_CN         = 4,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int REQ_W = req_flit_width(ADDR_WIDTH, DATA_WIDTH),
  localparam int RSP_W = rsp_flit_width(DATA_WIDTH)
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    pnse,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [NUM_CN-1:0]       rn_valid,
  input  logic [NUM_CN-1:0]       cn_ready,
  output logic [NUM_CN*REQ_W-1:0] icn_txreq,
  input  logic [NUM_CN-1:0]       cn_rsp_valid,
  output logic [NUM_CN-1:0]       rn_rsp_ready,
  input  logic [NUM_CN*RSP_W-1:0] icn_rxrsp
);
  rn_state_e           state, nxt;
  logic [REQ_W-1:0]    flit;
  logic [ID_WIDTH-1:0] dest;
  logic [RSP_W-1:0]    rsp;
  logic                ready_sel, rsp_valid_sel;
  logic [RSP_W-1:0]    rsp_sel;
  logic                mapped;

  assign mapped = ({1'b0, dest} < (ID_WIDTH+1)'(NUM_CN));

`ifdef RN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  logic [CW-1:0] cnt;
  logic          expired;
  // Budget spans REQ and WAIT together, so WAIT can expire on its first cycle.
  assign expired = (cnt >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                             cnt <= '0;
    else if (state == IDLE)                 cnt <= '0;
    else if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      flit  <= '0;
      dest  <= '0;
      rsp   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && psel && penable) begin
        flit <= {paddr, pprot, pnse, pwrite, pwdata, pstrb};
        dest <= paddr[ADDR_WIDTH-1 -: ID_WIDTH];
      end
      if (state == WAIT && rsp_valid_sel) rsp <= rsp_sel;
    end
  end

  // Unmapped IDs pass through one REQ cycle with no channel selected before ERR.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (psel && penable) nxt = REQ;
      REQ: begin
        if (!mapped)        nxt = ERR;
        else if (ready_sel) nxt = WAIT;
        else if (expired)   nxt = ERR;
      end
      WAIT: begin
        if (rsp_valid_sel)  nxt = RESP;
        else if (expired)   nxt = ERR;
      end
      RESP:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    pready  = (state == RESP) || (state == ERR);
    pslverr = (state == ERR) || (state == RESP && rsp[0]);
    prdata  = (state == RESP) ? rsp[RSP_W-1:1] : '0;
  end

  rn_port_demux #(
    .NUM_CN(NUM_CN), .ID_WIDTH(ID_WIDTH), .REQ_W(REQ_W), .RSP_W(RSP_W)
  ) u_demux (
    .dest          (dest),
    .req_en        (state == REQ),
    .rsp_en        (state == WAIT),
    .flit          (flit),
    .cn_ready      (cn_ready),
    .cn_rsp_valid  (cn_rsp_valid),
    .icn_rxrsp     (icn_rxrsp),
    .rn_valid      (rn_valid),
    .rn_rsp_ready  (rn_rsp_ready),
    .icn_txreq     (icn_txreq),
    .ready_sel     (ready_sel),
    .rsp_valid_sel (rsp_valid_sel),
    .rsp_sel       (rsp_sel)
  );
endmodule
